// File: rtl/mem_stage_if.sv
// Data-memory bus between mem_stage (master) and the data memory (slave).
// req/we/addr/wdata/be are held stable until ack; rdata is valid with ack.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM register, load/store unit with req/ack data-memory
// handshake and timeout, and MEM/WB register. Sources forwarding signals
// for execute and stalls the front of the pipe during memory accesses.
// Optional feature macro: MISALIGN_TRAP_EN (trap misaligned lh/lhu/sh/lw/sw).
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ALUResult_ex,
  input  logic [31:0] MemWriteData_ex,
  input  logic [4:0]  rdAddr_ex,
  input  logic        RegWrite_ex,
  input  logic        MemRead_ex,
  input  logic        MemWrite_ex,
  input  logic        MemtoReg_ex,
  input  logic [2:0]  funct3_ex,
  output logic [31:0] ALUResult_mem,
  output logic [4:0]  rdAddr_mem,
  output logic        RegWrite_mem,
  output logic        stall_mem,
  mem_stage_if.master bus,
  output logic [31:0] RegWriteData_wb,
  output logic [4:0]  rdAddr_wb,
  output logic        RegWrite_wb,
  output logic        bus_err,
  output logic        misalign_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // EX/MEM register fields
  logic [31:0] alu_q;
  logic [31:0] swdata_q;
  logic [4:0]  rd_q;
  logic        regwrite_q;
  logic        memread_q;
  logic        memwrite_q;
  logic        memtoreg_q;
  logic [2:0]  f3_q;

  // MEM/WB register fields
  logic [31:0] wbdata_q;
  logic [4:0]  wbrd_q;
  logic        wbwrite_q;

  logic        mem_op;
  logic [1:0]  off;
  logic        misalign;
  logic        timeout_hit;
  logic        stall;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] load_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign mem_op = memread_q | memwrite_q;
  assign off    = alu_q[1:0];

`ifdef MISALIGN_TRAP_EN
  // Misaligned word/halfword accesses are trapped instead of issued.
  always_comb begin
    misalign = 1'b0;
    if (mem_op) begin
      if (f3_q[1:0] == 2'b10 && off != 2'b00)
        misalign = 1'b1;
      else if (f3_q[1:0] == 2'b01 && off[0])
        misalign = 1'b1;
    end
  end
`else
  assign misalign = 1'b0;
`endif

  assign timeout_hit = (state_q == WAIT) && (cnt_q == CW'(TIMEOUT - 1)) && !bus.dmem_ack;
  assign stall       = mem_op && !bus.dmem_ack && !timeout_hit && !misalign;

  // EX/MEM pipeline register; holds while the memory access is outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_q      <= '0;
      swdata_q   <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      f3_q       <= '0;
    end else if (!stall) begin
      alu_q      <= ALUResult_ex;
      swdata_q   <= MemWriteData_ex;
      rd_q       <= rdAddr_ex;
      regwrite_q <= RegWrite_ex & ex_valid;
      memread_q  <= MemRead_ex & ex_valid;
      memwrite_q <= MemWrite_ex & ex_valid;
      memtoreg_q <= MemtoReg_ex;
      f3_q       <= funct3_ex;
    end
  end

  // Access FSM state and wait-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: IDLE issues, WAIT counts until ack or timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (mem_op && !misalign && !bus.dmem_ack) begin
          state_d = WAIT;
          cnt_d   = CW'(1);
        end
      end
      WAIT: begin
        if (bus.dmem_ack || timeout_hit) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Store lane steering and byte enables; loads enable all four lanes.
  always_comb begin
    be    = 4'b0000;
    wdata = swdata_q;
    if (memwrite_q) begin
      unique case (f3_q[1:0])
        2'b00: begin
          be    = 4'b0001 << off;
          wdata = {4{swdata_q[7:0]}};
        end
        2'b01: begin
          be    = 4'b0011 << {off[1], 1'b0};
          wdata = {2{swdata_q[15:0]}};
        end
        default: be = 4'b1111;
      endcase
    end else if (memread_q) begin
      be = 4'b1111;
    end
  end

  // Load lane extraction with sign/zero extension; a timed-out load yields 0.
  always_comb begin
    ld_byte   = 8'(bus.dmem_rdata >> {off, 3'b000});
    ld_half   = off[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    load_data = bus.dmem_rdata;
    unique case (f3_q)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {24'h000000, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  load_data = {16'h0000, ld_half};
      default: load_data = bus.dmem_rdata;
    endcase
    if (timeout_hit)
      load_data = '0;
  end

  // MEM/WB pipeline register; a stall inserts a write-back bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      wbdata_q  <= '0;
      wbrd_q    <= '0;
      wbwrite_q <= 1'b0;
    end else if (!stall) begin
      wbwrite_q <= regwrite_q & ~misalign;
      wbrd_q    <= rd_q;
      wbdata_q  <= memtoreg_q ? load_data : alu_q;
    end else begin
      wbwrite_q <= 1'b0;
    end
  end

  assign bus.dmem_req   = mem_op && !misalign &&
                          ((state_q == IDLE) || (state_q == WAIT));
  assign bus.dmem_we    = memwrite_q;
  assign bus.dmem_addr  = {alu_q[31:2], 2'b00};
  assign bus.dmem_wdata = wdata;
  assign bus.dmem_be    = be;

  assign ALUResult_mem   = alu_q;
  assign rdAddr_mem      = rd_q;
  assign RegWrite_mem    = regwrite_q;
  assign stall_mem       = stall;
  assign RegWriteData_wb = wbdata_q;
  assign rdAddr_wb       = wbrd_q;
  assign RegWrite_wb     = wbwrite_q;
  assign bus_err         = timeout_hit;
  assign misalign_err    = misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage (TIMEOUT=16).
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ALUResult_ex;
  logic [31:0] MemWriteData_ex;
  logic [4:0]  rdAddr_ex;
  logic        RegWrite_ex;
  logic        MemRead_ex;
  logic        MemWrite_ex;
  logic        MemtoReg_ex;
  logic [2:0]  funct3_ex;
  logic [31:0] ALUResult_mem;
  logic [4:0]  rdAddr_mem;
  logic        RegWrite_mem;
  logic        stall_mem;
  logic [31:0] RegWriteData_wb;
  logic [4:0]  rdAddr_wb;
  logic        RegWrite_wb;
  logic        bus_err;
  logic        misalign_err;

  int checks   = 0;
  int failures = 0;

  mem_stage_if bus();

  mem_stage #(.TIMEOUT(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .ex_valid        (ex_valid),
    .ALUResult_ex    (ALUResult_ex),
    .MemWriteData_ex (MemWriteData_ex),
    .rdAddr_ex       (rdAddr_ex),
    .RegWrite_ex     (RegWrite_ex),
    .MemRead_ex      (MemRead_ex),
    .MemWrite_ex     (MemWrite_ex),
    .MemtoReg_ex     (MemtoReg_ex),
    .funct3_ex       (funct3_ex),
    .ALUResult_mem   (ALUResult_mem),
    .rdAddr_mem      (rdAddr_mem),
    .RegWrite_mem    (RegWrite_mem),
    .stall_mem       (stall_mem),
    .bus             (bus),
    .RegWriteData_wb (RegWriteData_wb),
    .rdAddr_wb       (rdAddr_wb),
    .RegWrite_wb     (RegWrite_wb),
    .bus_err         (bus_err),
    .misalign_err    (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_ex(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] rd, input logic rw, input logic mr,
                        input logic mw, input logic m2r, input logic [2:0] f3);
    ex_valid        = v;
    ALUResult_ex    = alu;
    MemWriteData_ex = wd;
    rdAddr_ex       = rd;
    RegWrite_ex     = rw;
    MemRead_ex      = mr;
    MemWrite_ex     = mw;
    MemtoReg_ex     = m2r;
    funct3_ex       = f3;
  endtask

  task automatic bubble();
    set_ex(1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
  endtask

  task automatic alu_op(input logic [31:0] res, input logic [4:0] rd);
    @(negedge clk);
    set_ex(1'b1, res, 32'h0, rd, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    bubble();
    #1;
    check("alu_mem_result", ALUResult_mem, res);
    check("alu_mem_rd", rdAddr_mem, rd);
    check("alu_mem_we", RegWrite_mem, 1);
    check("alu_no_stall", stall_mem, 0);
    check("alu_no_req", bus.dmem_req, 0);
    @(negedge clk);
    check("alu_wb_data", RegWriteData_wb, res);
    check("alu_wb_rd", rdAddr_wb, rd);
    check("alu_wb_we", RegWrite_wb, 1);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] rdata, input int unsigned waits,
                         input logic [4:0] rd, input logic [31:0] exp);
    @(negedge clk);
    set_ex(1'b1, addr, 32'h0, rd, 1'b1, 1'b1, 1'b0, 1'b1, f3);
    for (int unsigned i = 0; i < waits; i++) begin
      @(negedge clk);
      bubble();
      #1;
      check("ld_stall", stall_mem, 1);
      check("ld_req", bus.dmem_req, 1);
      if (i == 1) check("ld_wb_bubble", RegWrite_wb, 0);
    end
    @(negedge clk);
    bubble();
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = rdata;
    #1;
    check("ld_req_ack", bus.dmem_req, 1);
    check("ld_addr", bus.dmem_addr, {addr[31:2], 2'b00});
    check("ld_be", bus.dmem_be, 4'hF);
    check("ld_we", bus.dmem_we, 0);
    check("ld_ack_no_stall", stall_mem, 0);
    @(negedge clk);
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h0;
    check("ld_data", RegWriteData_wb, exp);
    check("ld_wb_rd", rdAddr_wb, rd);
    check("ld_wb_we", RegWrite_wb, 1);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wd, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata);
    @(negedge clk);
    set_ex(1'b1, addr, wd, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, f3);
    @(negedge clk);
    bubble();
    bus.dmem_ack = 1'b1;
    #1;
    check("st_req", bus.dmem_req, 1);
    check("st_we", bus.dmem_we, 1);
    check("st_addr", bus.dmem_addr, {addr[31:2], 2'b00});
    check("st_be", bus.dmem_be, exp_be);
    check("st_wdata", bus.dmem_wdata, exp_wdata);
    check("st_no_stall", stall_mem, 0);
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    check("st_no_wb", RegWrite_wb, 0);
  endtask

  int stalls;

  initial begin
    reset          = 1'b1;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h0;
    bubble();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_alu_mem", ALUResult_mem, 0);
    check("rst_regwrite_mem", RegWrite_mem, 0);
    check("rst_req", bus.dmem_req, 0);
    check("rst_be", bus.dmem_be, 0);
    check("rst_stall", stall_mem, 0);
    check("rst_wb_data", RegWriteData_wb, 0);
    check("rst_wb_we", RegWrite_wb, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_misalign", misalign_err, 0);

    // Plain ALU op through both pipeline registers.
    alu_op(32'h0000_1234, 5'd5);

    // Loads with wait states and zero-wait, all width/extension variants.
    do_load(32'h0000_0103, 3'b000, 32'h80FF_FF7F, 3, 5'd7,  32'hFFFF_FF80);
    do_load(32'h0000_0103, 3'b100, 32'h80FF_FF7F, 3, 5'd8,  32'h0000_0080);
    do_load(32'h0000_0100, 3'b000, 32'h80FF_FF7F, 0, 5'd9,  32'h0000_007F);
    do_load(32'h0000_0102, 3'b001, 32'h80FF_FF7F, 1, 5'd10, 32'hFFFF_80FF);
    do_load(32'h0000_0100, 3'b101, 32'h80FF_FF7F, 0, 5'd11, 32'h0000_FF7F);
    do_load(32'h0000_0100, 3'b001, 32'h80FF_FF7F, 0, 5'd12, 32'hFFFF_FF7F);
    do_load(32'h0000_0104, 3'b010, 32'h80FF_FF7F, 2, 5'd13, 32'h80FF_FF7F);

    // Stores: lane steering and byte enables.
    do_store(32'h0000_0202, 3'b001, 32'hABCD_1234, 4'b1100, 32'h1234_1234);
    do_store(32'h0000_0101, 3'b000, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5);
    do_store(32'h0000_0208, 3'b010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

    // Timeout: lw never acked.
    @(negedge clk);
    set_ex(1'b1, 32'h0000_0300, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010);
    stalls = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bubble();
      #1;
      if (!stall_mem) break;
      check("to_no_err_early", bus_err, 0);
      stalls++;
    end
    check("to_stall_cycles", stalls, 15);
    check("to_bus_err", bus_err, 1);
    @(negedge clk);
    check("to_bus_err_pulse", bus_err, 0);
    check("to_wb_data", RegWriteData_wb, 0);
    check("to_wb_rd", rdAddr_wb, 9);
    check("to_wb_we", RegWrite_wb, 1);
    check("to_req_dropped", bus.dmem_req, 0);
    alu_op(32'h0000_5678, 5'd3);

    // Reset in the middle of WAIT.
    @(negedge clk);
    set_ex(1'b1, 32'h0000_0400, 32'h0, 5'd14, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010);
    @(negedge clk);
    bubble();
    @(negedge clk);
    check("rw_req_in_wait", bus.dmem_req, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rw_req", bus.dmem_req, 0);
    check("rw_stall", stall_mem, 0);
    check("rw_alu_mem", ALUResult_mem, 0);
    check("rw_regwrite_mem", RegWrite_mem, 0);
    check("rw_wb_data", RegWriteData_wb, 0);
    check("rw_wb_rd", rdAddr_wb, 0);
    check("rw_wb_we", RegWrite_wb, 0);
    @(negedge clk);
    check("rw_no_wb", RegWrite_wb, 0);
    alu_op(32'h0000_9ABC, 5'd6);

`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    set_ex(1'b1, 32'h0000_0102, 32'h0, 5'd15, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010);
    @(negedge clk);
    bubble();
    #1;
    check("ma_no_req", bus.dmem_req, 0);
    check("ma_err", misalign_err, 1);
    check("ma_no_stall", stall_mem, 0);
    @(negedge clk);
    check("ma_err_pulse", misalign_err, 0);
    check("ma_wb_we", RegWrite_wb, 0);
`else
    do_load(32'h0000_0102, 3'b010, 32'h1357_9BDF, 0, 5'd15, 32'h1357_9BDF);
    check("ma_err_tied", misalign_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Contains the EX/MEM pipeline register, a load/store unit with a req/ack data-memory handshake, and the MEM/WB pipeline register.
- Sources the forwarding signals that execute consumes: ALUResult_mem, rdAddr_mem, RegWrite_mem, RegWriteData_wb, rdAddr_wb and RegWrite_wb.
- Stalls the front of the pipe while a memory access is outstanding.

Parameters:
TIMEOUT, 16, maximum number of cycles in WAIT before an access is aborted with bus_err (must be 2 or more).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high reset.
ex_valid  input  1  execute stage holds a real instruction; 0 = bubble.
ALUResult_ex  input  32  ALU result, which is the address for loads and stores.
MemWriteData_ex  input  32  store data (rs2, after forwarding).
rdAddr_ex  input  5  destination register.
RegWrite_ex  input  1  instruction writes rd.
MemRead_ex  input  1  load.
MemWrite_ex  input  1  store.
MemtoReg_ex  input  1  write-back value is taken from the load path.
funct3_ex  input  3  access width: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; sb/sh/sw use 000/001/010.
ALUResult_mem  output  32  EX/MEM address/result, sent to forwarding.
rdAddr_mem  output  5  EX/MEM rd.
RegWrite_mem  output  1  EX/MEM write enable.
stall_mem  output  1  freeze the IF/ID/EX stages.
dmem_req  output  1  memory request.
dmem_we  output  1  1 = store.
dmem_addr  output  32  word-aligned address.
dmem_wdata  output  32  lane-replicated store data.
dmem_be  output  4  byte enables.
dmem_ack  input  1  access complete; dmem_rdata valid in the same cycle.
dmem_rdata  input  32  read word.
RegWriteData_wb  output  32  MEM/WB write-back data.
rdAddr_wb  output  5  MEM/WB rd.
RegWrite_wb  output  1  MEM/WB write enable.
bus_err  output  1  one-cycle pulse when an access times out.
misalign_err  output  1  one-cycle pulse on a misaligned access (feature-dependent).

Behaviour:
- Reset: every register and output is 0 and the state is IDLE. A reset in the middle of an access drops dmem_req on the edge after reset and discards the access.
- EX/MEM register:
  - When stall_mem=0, it captures all *_ex inputs on the clock edge.
  - When ex_valid=0, RegWrite, MemRead and MemWrite are captured as 0.
  - When stall_mem=1, it holds its contents.
- Definition: mem_op = MemRead_mem | MemWrite_mem.
- Handshake:
  - dmem_req = mem_op && (state==IDLE || state==WAIT), and it is not a first cycle that has already been completed.
  - dmem_addr = {ALUResult_mem[31:2],2'b00}.
  - addr, we, wdata and be stay stable while dmem_req=1 and dmem_ack=0.
  - An ack in the same cycle as the request is a zero-wait access: no stall.
  - stall_mem = mem_op && !dmem_ack && !timeout_hit.
- FSM:
  - IDLE: if mem_op and no ack, go to WAIT with the counter set to 1.
  - WAIT: an ack returns to IDLE. A counter value of TIMEOUT-1 with no ack sets timeout_hit, pulses bus_err, completes the load with data 0, drops the store, and returns to IDLE. Otherwise the counter increments.
- Store lanes (off = ALUResult_mem[1:0]):
  - sb: be = 4'b0001<<off, wdata = byte replicated ×4.
  - sh: be = 4'b0011<<{off[1],1'b0}, wdata = halfword replicated ×2.
  - sw: be = 4'b1111.
  - Loads drive be = 4'b1111.
- Load extraction:
  - lb/lbu select byte lane off; lh/lhu select halfword off[1]; lw takes the full word.
  - lb/lh sign-extend; lbu/lhu zero-extend.
- MEM/WB register:
  - When stall_mem=0: RegWrite_wb<=RegWrite_mem, rdAddr_wb<=rdAddr_mem, and RegWriteData_wb<= MemtoReg_mem ? load_data : ALUResult_mem.
  - When stall_mem=1: a bubble is inserted (RegWrite_wb<=0), and the other fields hold.
- Latency: a non-memory instruction appears on the *_wb outputs 2 edges after it is captured from EX. A memory access adds 1 edge for each wait cycle.
- Load-use hazards are not detected in this block; the decode-stage hazard unit handles them.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: misaligned accesses are trapped.
  - Misaligned means lw/sw with off!=0, or lh/lhu/sh with off[0]=1.
  - No dmem_req is issued and there is no stall.
  - misalign_err pulses high in that cycle.
  - RegWrite_wb for that instruction is forced to 0.
- Undefined: misalign_err is tied to 0.
  - lw/sw ignore off.
  - lh/sh use only off[1].

Test Plan:
1. ALU op with rd=5, ALUResult_ex=0x1234 and dmem_ack unused → ALUResult_mem=0x1234 after 1 edge; RegWriteData_wb=0x1234, rdAddr_wb=5, RegWrite_wb=1 after 2 edges; stall_mem stays 0.
2. lb at address 0x103, dmem_rdata=0x80FF_FF7F, ack after 3 wait cycles → stall_mem high for 3 cycles with a RegWrite_wb bubble; then RegWriteData_wb=0xFFFF_FF80. The same access as lbu gives 0x0000_0080.
3. sh at address 0x202 with MemWriteData_ex=0xABCD_1234 and zero-wait ack → dmem_addr=0x200, dmem_be=4'b1100, dmem_wdata=0x1234_1234, dmem_we=1, no stall.
4. lw with dmem_ack held at 0 and TIMEOUT=16 → stall for 15 cycles, a single bus_err pulse, RegWriteData_wb=0, then the pipe resumes.
5. reset asserted during WAIT → dmem_req=0 after that edge; all outputs 0; state IDLE; no write-back.
6. With MISALIGN_TRAP_EN defined, lw at address 0x102 → no dmem_req, misalign_err=1 for 1 cycle, RegWrite_wb=0. With it undefined, the same access reads word 0x100.
